// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel clock-enable strobe generator.
// Each channel emits single-cycle enable strobes with its own programmable
// divide ratio and phase. All channels share a common restart point (ALIGN)
// and are gated on a filtered, synchronised MMCM lock.
// Optional feature macro: CLKEN_LOCK_LOSS_CNT_EN (saturating lock-loss counter).
module clk_enable_gen #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 8,
    parameter int LOCK_CYC = 16,
    parameter int DIV_RST  = 4,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clkin1,
    input  logic              rst_n,
    input  logic              locked,
    input  logic              run,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] ce,
    output logic              active,
    output logic [7:0]        lock_loss_cnt
);

    localparam int               LC_W     = $clog2(LOCK_CYC + 1);
    localparam logic [LC_W-1:0]  LOCK_MAX = LC_W'(LOCK_CYC);
    localparam logic [LC_W-1:0]  LC_ONE   = LC_W'(1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_ALIGN     = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    // Effective divide: 0 and 1 both mean "strobe every cycle".
    function automatic logic [CNT_W-1:0] f_eff_div(input logic [CNT_W-1:0] div);
        return (div == CNT_ZERO) ? CNT_ONE : div;
    endfunction

    // Effective phase: clamped into the counter range 0..d-1.
    function automatic logic [CNT_W-1:0] f_eff_ph(input logic [CNT_W-1:0] div,
                                                  input logic [CNT_W-1:0] ph);
        logic [CNT_W-1:0] d_m1;
        d_m1 = f_eff_div(div) - CNT_ONE;
        return (ph > d_m1) ? d_m1 : ph;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_lk_meta;
    logic               r_lk;
    logic [LC_W-1:0]    r_lock_cnt;
    logic               w_lock_ok;
    logic               r_pending;
    logic               w_pending_nxt;
    logic               r_cfg_ready;
    logic               w_cfg_ready_nxt;
    logic               w_accept;
    logic               w_ch_ok;
    logic               w_ch0_wrap;
    logic               r_active;
    logic [NUM_CH-1:0]  r_ce;
    logic [NUM_CH-1:0]  w_ce_nxt;

    logic [CNT_W-1:0]   r_div      [NUM_CH];
    logic [CNT_W-1:0]   r_ph       [NUM_CH];
    logic [CNT_W-1:0]   r_div_sh   [NUM_CH];
    logic [CNT_W-1:0]   r_ph_sh    [NUM_CH];
    logic [CNT_W-1:0]   r_cnt      [NUM_CH];
    logic [CNT_W-1:0]   w_div_nxt  [NUM_CH];
    logic [CNT_W-1:0]   w_ph_nxt   [NUM_CH];
    logic [CNT_W-1:0]   w_div_sh_nxt [NUM_CH];
    logic [CNT_W-1:0]   w_ph_sh_nxt  [NUM_CH];
    logic [CNT_W-1:0]   w_cnt_nxt  [NUM_CH];

    assign w_lock_ok  = r_lk && (r_lock_cnt == LOCK_MAX);
    assign w_accept   = cfg_valid && r_cfg_ready;
    assign w_ch_ok    = (32'(cfg_ch) < 32'(NUM_CH));
    assign w_ch0_wrap = (r_cnt[0] == (f_eff_div(r_div[0]) - CNT_ONE));

    // Two-flop synchroniser for the asynchronous MMCM lock.
    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            r_lk_meta <= 1'b0;
            r_lk      <= 1'b0;
        end else begin
            r_lk_meta <= locked;
            r_lk      <= r_lk_meta;
        end
    end

    // Lock filter: clears on lock loss, saturates at LOCK_CYC.
    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= {LC_W{1'b0}};
        end else if (!r_lk) begin
            r_lock_cnt <= {LC_W{1'b0}};
        end else if (r_lock_cnt != LOCK_MAX) begin
            r_lock_cnt <= r_lock_cnt + LC_ONE;
        end else begin
            r_lock_cnt <= r_lock_cnt;
        end
    end

    // FSM state register.
    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT_LOCK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: lock loss has priority over run, run over pending updates.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_LOCK: begin
                if (w_lock_ok && run) begin
                    w_state_nxt = S_ALIGN;
                end else begin
                    w_state_nxt = S_WAIT_LOCK;
                end
            end
            S_ALIGN: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!r_lk) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (!run) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_pending && w_ch0_wrap) begin
                    w_state_nxt = S_ALIGN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
            end
        endcase
    end

    // Handshake next values: ALIGN consumes the pending update; no accept during ALIGN.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_state == S_ALIGN) begin
            w_pending_nxt = 1'b0;
        end else if (w_accept) begin
            w_pending_nxt = 1'b1;
        end else begin
            w_pending_nxt = r_pending;
        end
        w_cfg_ready_nxt = !w_pending_nxt && (w_state_nxt != S_ALIGN);
    end

    // Per-channel next values: shadow writes, ALIGN copy, counting and strobe decode.
    always_comb begin
        w_ce_nxt = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            w_div_sh_nxt[i] = r_div_sh[i];
            w_ph_sh_nxt[i]  = r_ph_sh[i];
            w_div_nxt[i]    = r_div[i];
            w_ph_nxt[i]     = r_ph[i];
            w_cnt_nxt[i]    = CNT_ZERO;

            if (w_accept && w_ch_ok && (32'(cfg_ch) == 32'(i))) begin
                w_div_sh_nxt[i] = cfg_div;
                w_ph_sh_nxt[i]  = cfg_phase;
            end else begin
                w_div_sh_nxt[i] = r_div_sh[i];
                w_ph_sh_nxt[i]  = r_ph_sh[i];
            end

            if (r_state == S_ALIGN) begin
                w_div_nxt[i] = r_div_sh[i];
                w_ph_nxt[i]  = r_ph_sh[i];
                w_cnt_nxt[i] = CNT_ZERO;
            end else if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
                if (r_cnt[i] == (f_eff_div(r_div[i]) - CNT_ONE)) begin
                    w_cnt_nxt[i] = CNT_ZERO;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                end
            end else begin
                w_cnt_nxt[i] = CNT_ZERO;
            end

            w_ce_nxt[i] = (w_state_nxt == S_RUN) &&
                          (w_cnt_nxt[i] == f_eff_ph(w_div_nxt[i], w_ph_nxt[i]));
        end
    end

    // Channel registers: active and shadow configuration plus phase counters.
    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i]    <= DIV_INIT;
                r_ph[i]     <= CNT_ZERO;
                r_div_sh[i] <= DIV_INIT;
                r_ph_sh[i]  <= CNT_ZERO;
                r_cnt[i]    <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i]    <= w_div_nxt[i];
                r_ph[i]     <= w_ph_nxt[i];
                r_div_sh[i] <= w_div_sh_nxt[i];
                r_ph_sh[i]  <= w_ph_sh_nxt[i];
                r_cnt[i]    <= w_cnt_nxt[i];
            end
        end
    end

    // Registered outputs and handshake state.
    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            r_ce        <= {NUM_CH{1'b0}};
            r_active    <= 1'b0;
            r_pending   <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_ce        <= w_ce_nxt;
            r_active    <= (w_state_nxt == S_RUN);
            r_pending   <= w_pending_nxt;
            r_cfg_ready <= w_cfg_ready_nxt;
        end
    end

    assign ce        = r_ce;
    assign active    = r_active;
    assign cfg_ready = r_cfg_ready;

`ifdef CLKEN_LOCK_LOSS_CNT_EN
    logic [7:0] r_lock_loss_cnt;

    // Count RUN exits caused by lock loss, saturating at 255.
    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_loss_cnt <= 8'd0;
        end else if ((r_state == S_RUN) && !r_lk && (r_lock_loss_cnt != 8'hFF)) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
        end else begin
            r_lock_loss_cnt <= r_lock_loss_cnt;
        end
    end

    assign lock_loss_cnt = r_lock_loss_cnt;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed self-checking bench for clk_enable_gen (NUM_CH=2, CNT_W=8,
// LOCK_CYC=16, DIV_RST=4). Expected strobe patterns are hand-derived.
module tb_clk_enable_gen;

    logic       clkin1;
    logic       rst_n;
    logic       locked;
    logic       run;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [7:0] cfg_phase;
    logic [1:0] ce;
    logic       active;
    logic [7:0] lock_loss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    clk_enable_gen dut (
        .clkin1        (clkin1),
        .rst_n         (rst_n),
        .locked        (locked),
        .run           (run),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_ch        (cfg_ch),
        .cfg_div       (cfg_div),
        .cfg_phase     (cfg_phase),
        .ce            (ce),
        .active        (active),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial clkin1 = 1'b0;
    always #5 clkin1 = ~clkin1;

    // advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clkin1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From rst_n release with locked=1, run=1: 2 sync + 16 filter + 1 ALIGN quiet
    // edges, then both default channels (div 4, phase 0) strobe together.
    task automatic startup(input string tag);
        for (int k = 1; k <= 19; k++) begin
            tick();
            chk({tag, "_quiet"}, {29'd0, active, ce}, 32'd0);
        end
        tick();
        chk({tag, "_first_ce"}, {30'd0, ce}, 32'd3);
        chk({tag, "_active"}, {31'd0, active}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk({tag, "_gap"}, {30'd0, ce}, 32'd0);
        end
        tick();
        chk({tag, "_second_ce"}, {30'd0, ce}, 32'd3);
    endtask

    // wait (bounded) for the one-cycle ALIGN, visible as active low
    task automatic wait_align(input string tag);
        for (int k = 0; k < 8; k++) begin
            if (active === 1'b0) break;
            tick();
        end
        chk({tag, "_align_seen"}, {31'd0, active}, 32'd0);
        chk({tag, "_align_ce"}, {30'd0, ce}, 32'd0);
    endtask

    logic [1:0] exp_ce;
    logic [7:0] exp_llc;

    initial begin
`ifdef CLKEN_LOCK_LOSS_CNT_EN
        exp_llc = 8'd1;
`else
        exp_llc = 8'd0;
`endif
        rst_n     = 1'b0;
        locked    = 1'b1;
        run       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd0;
        cfg_phase = 8'd0;
        tick();
        tick();
        chk("rst_ce", {30'd0, ce}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_llc", {24'd0, lock_loss_cnt}, 32'd0);
        rst_n = 1'b1;

        // 1: power-up sequence
        startup("start");

        // 2: ch1 div=6 phase=2 written while ch0 counter is at 1
        tick();
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd6; cfg_phase = 8'd2;
        tick();
        cfg_valid = 1'b0;
        chk("upd_ready_lo", {31'd0, cfg_ready}, 32'd0);
        tick();
        chk("upd_ready_wait", {31'd0, cfg_ready}, 32'd0);
        chk("upd_ce_wait", {30'd0, ce}, 32'd0);
        tick();
        chk("upd_align_active", {31'd0, active}, 32'd0);
        chk("upd_align_ce", {30'd0, ce}, 32'd0);
        chk("upd_align_ready", {31'd0, cfg_ready}, 32'd0);
        for (int s = 1; s <= 16; s++) begin
            tick();
            exp_ce = {((s - 1) % 6 == 2), ((s - 1) % 4 == 0)};
            chk("upd_pattern", {30'd0, ce}, {30'd0, exp_ce});
            if (s == 1) chk("upd_ready_hi", {31'd0, cfg_ready}, 32'd1);
        end

        // 3a: ch1 div=0 -> held high
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd0; cfg_phase = 8'd0;
        tick();
        cfg_valid = 1'b0;
        chk("div0_ready_lo", {31'd0, cfg_ready}, 32'd0);
        wait_align("div0");
        for (int s = 1; s <= 8; s++) begin
            tick();
            exp_ce = {1'b1, ((s - 1) % 4 == 0)};
            chk("div0_pattern", {30'd0, ce}, {30'd0, exp_ce});
        end

        // 3b: ch1 div=3 phase=7 -> phase clamps to 2
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd3; cfg_phase = 8'd7;
        tick();
        cfg_valid = 1'b0;
        wait_align("clamp");
        for (int s = 1; s <= 9; s++) begin
            tick();
            exp_ce = {((s - 1) % 3 == 2), ((s - 1) % 4 == 0)};
            chk("clamp_pattern", {30'd0, ce}, {30'd0, exp_ce});
        end

        // 4: one-cycle lock drop
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        tick();
        chk("lol_ce", {30'd0, ce}, 32'd0);
        chk("lol_active", {31'd0, active}, 32'd0);
        chk("lol_cnt", {24'd0, lock_loss_cnt}, {24'd0, exp_llc});
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk("lol_refilter", {29'd0, active, ce}, 32'd0);
        end
        for (int s = 1; s <= 6; s++) begin
            tick();
            exp_ce = {((s - 1) % 3 == 2), ((s - 1) % 4 == 0)};
            chk("lol_restart", {30'd0, ce}, {30'd0, exp_ce});
            if (s == 1) chk("lol_active_back", {31'd0, active}, 32'd1);
        end

        // 5: run low for 10 cycles mid-period, then restart from ALIGN
        run = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("run_off_quiet", {29'd0, active, ce}, 32'd0);
        end
        run = 1'b1;
        tick();
        chk("run_on_align", {29'd0, active, ce}, 32'd0);
        for (int s = 1; s <= 9; s++) begin
            tick();
            exp_ce = {((s - 1) % 3 == 2), ((s - 1) % 4 == 0)};
            chk("run_on_pattern", {30'd0, ce}, {30'd0, exp_ce});
        end

        // 6: asynchronous reset while both strobes are high
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ce", {30'd0, ce}, 32'd0);
        chk("arst_active", {31'd0, active}, 32'd0);
        chk("arst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("arst_llc", {24'd0, lock_loss_cnt}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        startup("rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Parametrised multi-channel clock-enable generator.
- Runs on the MMCM output clock and produces NUM_CH single-cycle enable strobes. Each strobe has its own run-time-programmable divide ratio and phase.
- Replaces fixed MMCM divider ratios for sample/activity timing.
- Gates all strobes on a filtered MMCM lock, and phase-aligns all channels to a common restart point.

Parameters:
- NUM_CH, 2, number of enable channels (1-16).
- CNT_W, 8, width of the divide and phase fields.
- LOCK_CYC, 16, consecutive cycles `locked` must stay high before strobes start (>=1).
- DIV_RST, 4, reset divide ratio for every channel.

Ports:
- clkin1  in  1  block clock (MMCM output after BUFG)
- rst_n  in  1  asynchronous active-low reset
- locked  in  1  MMCM LOCKED; treated as asynchronous, 2-flop synchronised internally
- run  in  1  level; 1 = generate strobes, 0 = hold all channels idle
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  block can accept a configuration write
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_div  in  CNT_W  divide ratio
- cfg_phase  in  CNT_W  phase offset in cycles
- ce  out  NUM_CH  per-channel enable strobes
- active  out  1  high while in RUN
- lock_loss_cnt  out  8  lock-loss event count (optional feature)

Behaviour:
- Reset is asynchronous (assert on rst_n low), deassertion is synchronous. Reset values:
  - ce=0, active=0, cfg_ready=1, lock_loss_cnt=0.
  - State = WAIT_LOCK.
  - Every channel: div=DIV_RST, phase=0; shadow registers equal to the active registers.
- Lock filter:
  - The synchronised lock input (lk) feeds a LOCK_CYC counter.
  - The counter clears whenever lk=0 and saturates at LOCK_CYC.
  - lock_ok = (counter == LOCK_CYC).
- FSM states: WAIT_LOCK, ALIGN, RUN.
  - WAIT_LOCK -> ALIGN when lock_ok & run.
  - ALIGN lasts exactly 1 cycle:
    - copy every shadow register into its active register;
    - load all channel counters with 0;
    - ce=0;
    - next state RUN.
  - RUN -> WAIT_LOCK when lk=0. Takes effect on the first cycle lk is seen low. ce forced 0 in that same cycle; the filter counter clears.
  - RUN -> WAIT_LOCK when run=0. ce=0 from the next cycle.
  - RUN -> ALIGN when an update is pending (see configuration handshake).
- Channel counting in RUN:
  - Counter counts 0..d-1 and wraps to 0.
  - Effective divide d = max(div,1); div of 0 or 1 gives ce held high continuously.
  - Effective phase p = min(phase, d-1).
  - ce[i] = 1 for exactly the cycle in which the counter equals p. This is a registered output.
  - First strobe appears p+1 cycles after the ALIGN cycle. All channels share this time zero.
- Configuration handshake:
  - A write is accepted on any cycle where cfg_valid & cfg_ready; it writes {cfg_div, cfg_phase} into shadow[cfg_ch].
  - cfg_ch >= NUM_CH: the write is accepted and discarded.
  - An accepted write sets `pending`; cfg_ready=0 while pending.
  - In RUN with pending set, the FSM waits for the wrap of channel 0 (counter at d0-1), then enters ALIGN. ALIGN clears pending, so cfg_ready=1 on the cycle after ALIGN.
  - In WAIT_LOCK, accepted writes leave pending set. The next ALIGN applies them.
  - cfg_valid together with an ALIGN in the same cycle: the write is not accepted, because cfg_ready=0.
- active=1 exactly in RUN.
- Arithmetic is unsigned CNT_W. Values are truncated, never overflow-checked.

Optional Feature:
- Macro CLKEN_LOCK_LOSS_CNT_EN.
- Defined:
  - lock_loss_cnt increments by 1 on each RUN -> WAIT_LOCK transition caused by lk=0.
  - It saturates at 255 and is cleared only by rst_n.
- Undefined: lock_loss_cnt tied to 0; no counter logic is present.

Test Plan:
- Reset with locked=1, run=1, LOCK_CYC=16 -> ce=0 for 2 sync + 16 filter cycles + 1 ALIGN; then ce[0] and ce[1] pulse every 4 cycles, both in the same cycle.
- Write ch1 div=6 phase=2 while ch0 runs div=4 -> cfg_ready=0 until channel 0 wraps; ALIGN; ch1 first pulse 3 cycles after ALIGN, then every 6 cycles; cfg_ready=1 after ALIGN.
- Write div=0, then div=3 phase=7 -> first case: ce held high; second case: phase clamped to 2, pulse every 3rd cycle at count 2.
- Drop locked for 1 cycle in RUN -> ce=0 within 3 cycles, active=0; restart only after 16 fresh lock cycles; with CLKEN_LOCK_LOSS_CNT_EN, lock_loss_cnt=1.
- Deassert run mid-period, reassert 10 cycles later -> ce silent meanwhile; ALIGN restarts all channel counters from 0.
- Assert rst_n low asynchronously mid-RUN -> ce=0 and active=0 immediately; shadow div returns to 4.
